// File: rtl/cp_remove_pkg.sv
// Shared constants and FSM encoding for the OFDM cyclic-prefix removal stage.
// Constants only: no latency, no flow control.
package cp_remove_pkg;

  localparam int FFT_N        = 512;
  localparam int CP_LEN_SAMP  = 32;
  localparam int MAX_NUM      = 10;
  localparam int SYM_MAX_DFLT = MAX_NUM - 3;
  localparam int SAMP_DW      = 12;
  localparam int IDLE_TIMEOUT = 1023;
  localparam int SYM_IDX_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_DATA,
    ST_TAIL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cp_remove_if.sv
// Sample-stream bundle: separated signal/payload samples in, useful FFT samples out.
// Valid-only: the sample stream has no ready, and it cannot be stalled.
interface cp_remove_if
  import cp_remove_pkg::*;
#(
  parameter int DW = SAMP_DW
);

  logic signed [DW-1:0]        di_re;
  logic signed [DW-1:0]        di_im;
  logic                        di_vld;
  logic signed [DW-1:0]        do_re;
  logic signed [DW-1:0]        do_im;
  logic                        do_vld;
  logic                        do_sop;
  logic                        do_eop;
  logic [SYM_IDX_W-1:0]        do_sym_idx;
  logic                        frame_done;
  logic                        frame_abort;

  modport slave (
    input  di_re, di_im, di_vld,
    output do_re, do_im, do_vld, do_sop, do_eop, do_sym_idx, frame_done, frame_abort
  );

  modport master (
    output di_re, di_im, di_vld,
    input  do_re, do_im, do_vld, do_sop, do_eop, do_sym_idx, frame_done, frame_abort
  );

endinterface

// File: rtl/cp_remove.sv
// Splits the sample stream into CP_LEN+N symbols, drops the CP, frames SYM_MAX symbols.
// Latency 1 cycle from an accepted sample to do_vld; no backpressure, gaps pass through.
module cp_remove
  import cp_remove_pkg::*;
#(
  parameter int N       = FFT_N,
  parameter int CP_LEN  = CP_LEN_SAMP,
  parameter int CP_SKIP = CP_LEN_SAMP,
  parameter int SYM_MAX = SYM_MAX_DFLT,
  parameter int TIMEOUT = IDLE_TIMEOUT
) (
  input  logic      clk,
  input  logic      rst,
  cp_remove_if.slave bus
);

  localparam int SW = $clog2(CP_LEN + N);
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0]        SKIP_END = SW'(CP_SKIP);
  localparam logic [SW-1:0]        DATA_END = SW'(CP_SKIP + N - 1);
  localparam logic [SW-1:0]        SYM_END  = SW'(CP_LEN + N - 1);
  localparam logic [SYM_IDX_W-1:0] LAST_SYM = SYM_IDX_W'(SYM_MAX - 1);
  localparam logic [IW-1:0]        IDLE_LIM = IW'(TIMEOUT);

  state_t               state, state_nxt;
  logic [SW-1:0]        samp_cnt, samp_nxt, cur_samp, samp_inc;
  logic [SYM_IDX_W-1:0] sym_cnt, sym_nxt, cur_sym;
  logic [IW-1:0]        idle_cnt, idle_nxt;
  logic                 accept, pass, sop_nxt, eop_nxt, done_nxt, abort_nxt;

  always_comb begin
    state_nxt = state;
    samp_nxt  = samp_cnt;
    sym_nxt   = sym_cnt;
    idle_nxt  = idle_cnt;
    accept    = 1'b0;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    // The sample that wakes IDLE is position 0 of symbol 0.
    cur_samp  = (state == ST_IDLE) ? '0 : samp_cnt;
    cur_sym   = (state == ST_IDLE) ? '0 : sym_cnt;
    samp_inc  = cur_samp + 1'b1;

    unique case (state)
      ST_IDLE: begin
        accept   = bus.di_vld;
        idle_nxt = '0;
      end
      ST_SKIP, ST_DATA, ST_TAIL: begin
        if (bus.di_vld) begin
          accept   = 1'b1;
          idle_nxt = '0;
        end else if (idle_cnt == IDLE_LIM) begin
          abort_nxt = 1'b1;
          state_nxt = ST_IDLE;
          samp_nxt  = '0;
          sym_nxt   = '0;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    pass    = accept && (state == ST_DATA || (state == ST_IDLE && SKIP_END == '0));
    sop_nxt = pass && (cur_samp == SKIP_END);
    eop_nxt = pass && (cur_samp == DATA_END);

    if (accept) begin
      if (cur_samp == SYM_END) begin
        samp_nxt = '0;
        if (cur_sym == LAST_SYM) begin
          sym_nxt   = '0;
          state_nxt = ST_DONE;
        end else begin
          sym_nxt   = cur_sym + 1'b1;
          state_nxt = (SKIP_END == '0) ? ST_DATA : ST_SKIP;
        end
      end else begin
        samp_nxt = samp_inc;
        if (samp_inc < SKIP_END)       state_nxt = ST_SKIP;
        else if (samp_inc <= DATA_END) state_nxt = ST_DATA;
        else                           state_nxt = ST_TAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      samp_cnt        <= '0;
      sym_cnt         <= '0;
      idle_cnt        <= '0;
      bus.do_re       <= '0;
      bus.do_im       <= '0;
      bus.do_vld      <= 1'b0;
      bus.do_sop      <= 1'b0;
      bus.do_eop      <= 1'b0;
      bus.do_sym_idx  <= '0;
      bus.frame_done  <= 1'b0;
      bus.frame_abort <= 1'b0;
    end else begin
      state           <= state_nxt;
      samp_cnt        <= samp_nxt;
      sym_cnt         <= sym_nxt;
      idle_cnt        <= idle_nxt;
      bus.do_vld      <= pass;
      bus.do_sop      <= sop_nxt;
      bus.do_eop      <= eop_nxt;
      bus.frame_done  <= done_nxt;
      bus.frame_abort <= abort_nxt;
      // Sample and index registers hold across gaps.
      if (pass) begin
        bus.do_re      <= bus.di_re;
        bus.do_im      <= bus.di_im;
        bus.do_sym_idx <= cur_sym;
      end
    end
  end

endmodule

// File: tb/tb_cp_remove.sv
// Drives one stream into two cp_remove instances (CP_SKIP 32 and 16) and compares every
// output on every cycle against a frame-position reference model.
module tb_cp_remove;
  import cp_remove_pkg::*;

  localparam int L     = CP_LEN_SAMP + FFT_N;
  localparam int FRAME = SYM_MAX_DFLT * L;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] di_re = '0;
  logic [11:0] di_im = '0;
  logic        di_vld = 1'b0;

  always #5 clk = ~clk;

  cp_remove_if #(.DW(SAMP_DW)) bus0 ();
  cp_remove_if #(.DW(SAMP_DW)) bus1 ();

  assign bus0.di_re  = di_re;
  assign bus0.di_im  = di_im;
  assign bus0.di_vld = di_vld;
  assign bus1.di_re  = di_re;
  assign bus1.di_im  = di_im;
  assign bus1.di_vld = di_vld;

  cp_remove #(.CP_SKIP(32)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  cp_remove #(.CP_SKIP(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_chk = 0;
  int n_err = 0;

  int          skip_of [2];
  bit          m_act [2];
  bit          m_done [2];
  int          m_pos [2];
  int          m_idle [2];
  logic        e_vld [2];
  logic        e_sop [2];
  logic        e_eop [2];
  logic        e_fd [2];
  logic        e_fa [2];
  logic [2:0]  e_idx [2];
  logic [11:0] e_re [2];
  logic [11:0] e_im [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 1'b0; m_done[d] = 1'b0; m_pos[d] = 0; m_idle[d] = 0;
      e_vld[d] = 1'b0; e_sop[d] = 1'b0; e_eop[d] = 1'b0; e_fd[d] = 1'b0; e_fa[d] = 1'b0;
      e_idx[d] = '0; e_re[d] = '0; e_im[d] = '0;
    end
  endtask

  // Position in frame decides everything: symbol = pos / L, offset = pos % L.
  task automatic model_step(input int d);
    int samp;
    int sym;
    e_vld[d] = 1'b0; e_sop[d] = 1'b0; e_eop[d] = 1'b0; e_fd[d] = 1'b0; e_fa[d] = 1'b0;
    if (m_done[d]) begin
      e_fd[d]   = 1'b1;
      m_done[d] = 1'b0;
    end else if (di_vld) begin
      if (!m_act[d]) begin
        m_act[d] = 1'b1;
        m_pos[d] = 0;
      end
      m_idle[d] = 0;
      samp = m_pos[d] % L;
      sym  = m_pos[d] / L;
      if (samp >= skip_of[d] && samp < skip_of[d] + FFT_N) begin
        e_vld[d] = 1'b1;
        e_sop[d] = (samp == skip_of[d]);
        e_eop[d] = (samp == skip_of[d] + FFT_N - 1);
        e_idx[d] = sym[2:0];
        e_re[d]  = di_re;
        e_im[d]  = di_im;
      end
      m_pos[d]++;
      if (m_pos[d] == FRAME) begin
        m_act[d]  = 1'b0;
        m_done[d] = 1'b1;
      end
    end else if (m_act[d]) begin
      if (m_idle[d] == IDLE_TIMEOUT) begin
        e_fa[d]   = 1'b1;
        m_act[d]  = 1'b0;
        m_idle[d] = 0;
      end else begin
        m_idle[d]++;
      end
    end
  endtask

  task automatic check_all(input int d);
    logic [11:0] re, im;
    logic        v, s, e, fd, fa;
    logic [2:0]  idx;
    if (d == 0) begin
      re = bus0.do_re; im = bus0.do_im; v = bus0.do_vld; s = bus0.do_sop; e = bus0.do_eop;
      idx = bus0.do_sym_idx; fd = bus0.frame_done; fa = bus0.frame_abort;
    end else begin
      re = bus1.do_re; im = bus1.do_im; v = bus1.do_vld; s = bus1.do_sop; e = bus1.do_eop;
      idx = bus1.do_sym_idx; fd = bus1.frame_done; fa = bus1.frame_abort;
    end
    chk($sformatf("d%0d_vld", d),   {31'd0, v},   {31'd0, e_vld[d]});
    chk($sformatf("d%0d_sop", d),   {31'd0, s},   {31'd0, e_sop[d]});
    chk($sformatf("d%0d_eop", d),   {31'd0, e},   {31'd0, e_eop[d]});
    chk($sformatf("d%0d_done", d),  {31'd0, fd},  {31'd0, e_fd[d]});
    chk($sformatf("d%0d_abort", d), {31'd0, fa},  {31'd0, e_fa[d]});
    chk($sformatf("d%0d_idx", d),   {29'd0, idx}, {29'd0, e_idx[d]});
    chk($sformatf("d%0d_re", d),    {20'd0, re},  {20'd0, e_re[d]});
    chk($sformatf("d%0d_im", d),    {20'd0, im},  {20'd0, e_im[d]});
  endtask

  task automatic cycle(input logic v, input logic [11:0] re, input logic [11:0] im);
    di_vld = v;
    di_re  = re;
    di_im  = im;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all(0);
    check_all(1);
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 12'($urandom), 12'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 12'($urandom), 12'($urandom));
  endtask

  initial begin
    skip_of[0] = 32;
    skip_of[1] = 16;
    model_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all(0);
    check_all(1);
    rst = 1'b1;
    idle(3);

    // Index ramp frame, then a sample landing in DONE, then a random contiguous frame.
    for (int i = 0; i < FRAME; i++) cycle(1'b1, i[11:0], ~i[11:0]);
    send(1);
    idle(1);
    send(FRAME);
    idle(4);

    // One-in-three duty cycle over a whole frame.
    for (int i = 0; i < 3 * FRAME; i++) cycle(i % 3 == 0, 12'($urandom), 12'($urandom));
    idle(2);

    // Random short gaps.
    for (int sent = 0; sent < FRAME; ) begin
      if ($urandom_range(3, 0) != 0) begin
        send(1);
        sent++;
      end else begin
        idle($urandom_range(4, 1));
      end
    end
    idle(5);

    // Stall in symbol 2 long enough to abort, then a gap that sits exactly on the limit.
    send(2 * L + 300);
    idle(IDLE_TIMEOUT + 3);
    send(100);
    idle(IDLE_TIMEOUT);
    send(600);

    // Asynchronous reset mid-symbol.
    rst = 1'b0;
    #1;
    model_reset();
    check_all(0);
    check_all(1);
    @(negedge clk);
    check_all(0);
    check_all(1);
    rst = 1'b1;
    send(600);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
